// File: rtl/logic_op_pkg.sv
// Shared opcode encoding and queue sizing for logic_op_pipe and its gate slices.
package logic_op_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  // Encodings at or above this value have no gate and yield an error result.
  localparam logic [2:0] LOGIC_OP_ILLEGAL_MIN = 3'd6;

  localparam int QDEPTH = 2;

endpackage

// File: rtl/logic_op_pipe_gate_mux_slice.sv
// One-bit gate built as a 2:1 mux: A selects, data comes from B, ~B or a constant.
module gate_mux_slice
  import logic_op_pkg::*;
(
  input  logic a,
  input  logic b,
  input  op_e  op,
  output logic y,
  output logic illegal
);

  logic d0;
  logic d1;

  always_comb begin
    d0      = 1'b0;
    d1      = 1'b0;
    illegal = (op >= LOGIC_OP_ILLEGAL_MIN);
    case (op)
      OP_AND:  begin d0 = 1'b0; d1 = b;    end
      OP_OR:   begin d0 = b;    d1 = 1'b1; end
      OP_NAND: begin d0 = 1'b1; d1 = ~b;   end
      OP_NOR:  begin d0 = ~b;   d1 = 1'b0; end
      OP_XOR:  begin d0 = b;    d1 = ~b;   end
      OP_XNOR: begin d0 = ~b;   d1 = b;    end
      default: begin d0 = 1'b0; d1 = 1'b0; end
    endcase
    y = a ? d1 : d0;
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Handshaked bitwise gate front-end with a 2-entry result queue and saturating op counter.
// Optional LOGIC_OP_PARITY_EN adds out_par, the XOR reduction of the head result.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_err,
`ifdef LOGIC_OP_PARITY_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] op_count
);

  // Handshake: a transfer happens on a side exactly when its valid and ready are
  // both high at the rising edge; ready never looks at the same side's valid.

`ifdef LOGIC_OP_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  // Entry layout: {[par,] err, y}
  localparam int EW = WIDTH + 1 + PW;

  logic [WIDTH-1:0] res_y;
  logic [WIDTH-1:0] illegal_vec;
  logic             res_err;
  logic [EW-1:0]    new_entry;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
    gate_mux_slice u_slice (
      .a       (in_a[gi]),
      .b       (in_b[gi]),
      .op      (op_e'(in_op)),
      .y       (res_y[gi]),
      .illegal (illegal_vec[gi])
    );
  end

  assign res_err = |illegal_vec;

`ifdef LOGIC_OP_PARITY_EN
  assign new_entry = {^res_y, res_err, res_y};
`else
  assign new_entry = {res_err, res_y};
`endif

  logic [EW-1:0]    slot0_q, slot0_d;
  logic [EW-1:0]    slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push;
  logic             pop;

  assign out_valid = (count_q != 2'd0);
  // Full only blocks input when the head is not leaving this cycle.
  assign in_ready  = !((count_q == 2'(QDEPTH)) && !out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    if (push && pop) begin
      if (count_q == 2'd2) begin
        slot0_d = slot1_q;
        slot1_d = new_entry;
      end else begin
        slot0_d = new_entry;
      end
    end else if (push) begin
      if (count_q == 2'd0) slot0_d = new_entry;
      else                 slot1_d = new_entry;
      count_d = count_q + 2'd1;
    end else if (pop) begin
      slot0_d = slot1_q;
      slot1_d = '0;
      count_d = count_q - 2'd1;
    end
    if (push && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
      cnt_q   <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_y    = slot0_q[WIDTH-1:0];
  assign out_err  = slot0_q[WIDTH];
  assign op_count = cnt_q;
`ifdef LOGIC_OP_PARITY_EN
  assign out_par  = slot0_q[WIDTH+1];
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe: reset, truth table, backpressure, illegal ops,
// async reset, and counter saturation on a CNT_W=4 instance.
module tb_logic_op_pipe;
  import logic_op_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_err;
  logic [15:0] op_count;

  logic       s_in_valid;
  logic       s_in_ready;
  logic       s_out_valid;
  logic       s_out_ready;
  logic [7:0] s_out_y;
  logic       s_out_err;
  logic [3:0] s_op_count;
`ifdef LOGIC_OP_PARITY_EN
  logic       out_par;
  logic       s_out_par;
`endif

  int n_vec;
  int n_err;

  logic [7:0] tt_exp[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_err   (out_err),
`ifdef LOGIC_OP_PARITY_EN
    .out_par   (out_par),
`endif
    .op_count  (op_count)
  );

  logic_op_pipe #(.WIDTH(8), .CNT_W(4)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_a      (8'h0F),
    .in_b      (8'h33),
    .in_op     (3'd0),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_y     (s_out_y),
    .out_err   (s_out_err),
`ifdef LOGIC_OP_PARITY_EN
    .out_par   (s_out_par),
`endif
    .op_count  (s_op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    tt_exp[0] = 8'h88; tt_exp[1] = 8'hEE; tt_exp[2] = 8'h77;
    tt_exp[3] = 8'h11; tt_exp[4] = 8'h66; tt_exp[5] = 8'h99;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    out_ready   = 1'b1;
    rst_n       = 1'b0;
    drive(1'b1, 8'hFF, 8'hFF, 3'd1);

    // Reset held with in_valid high: nothing is accepted
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'h00);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
`ifdef LOGIC_OP_PARITY_EN
    chk("rst_out_par", 32'(out_par), 32'd0);
`endif
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_count", 32'(op_count), 32'd0);

    // Truth table A=CC B=AA, one op per cycle, latency 1
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(1'b1, 8'hCC, 8'hAA, 3'(k));
      @(posedge clk); #1;
      chk($sformatf("tt_valid_op%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("tt_y_op%0d", k), 32'(out_y), 32'(tt_exp[k]));
      chk($sformatf("tt_err_op%0d", k), 32'(out_err), 32'd0);
`ifdef LOGIC_OP_PARITY_EN
      chk($sformatf("tt_par_op%0d", k), 32'(out_par), 32'(^tt_exp[k]));
`endif
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    @(posedge clk); #1;
    chk("tt_drained", 32'(out_valid), 32'd0);
    chk("tt_count", 32'(op_count), 32'd6);

    // Backpressure: two fill the queue, third waits
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 8'hF0, 8'h0F, 3'd1);
    #1 chk("bp_ready_empty", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 8'hF0, 8'hFF, 3'd0);
    @(posedge clk); #1;
    chk("bp_head_first", 32'(out_y), 32'hFF);
    @(negedge clk);
    drive(1'b1, 8'h00, 8'h3C, 3'd4);
    #1 chk("bp_full_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("bp_hold_y", 32'(out_y), 32'hFF);
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_count", 32'(op_count), 32'd8);
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_full_pop_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    chk("bp_drain_1", 32'(out_y), 32'hF0);
    chk("bp_third_count", 32'(op_count), 32'd9);
    @(posedge clk); #1;
    chk("bp_drain_2", 32'(out_y), 32'h3C);
    chk("bp_drain_2_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Illegal opcodes 7 and 6, then a legal AND
    @(negedge clk);
    drive(1'b1, 8'hFF, 8'hFF, 3'd7);
    @(posedge clk); #1;
    chk("ill7_y", 32'(out_y), 32'h00);
    chk("ill7_err", 32'(out_err), 32'd1);
    chk("ill7_count", 32'(op_count), 32'd10);
    drive(1'b1, 8'h5A, 8'hC3, 3'd6);
    @(posedge clk); #1;
    chk("ill6_y", 32'(out_y), 32'h00);
    chk("ill6_err", 32'(out_err), 32'd1);
    drive(1'b1, 8'hFF, 8'h0F, 3'd0);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    chk("legal_after_y", 32'(out_y), 32'h0F);
    chk("legal_after_err", 32'(out_err), 32'd0);
    chk("legal_after_count", 32'(op_count), 32'd12);
    @(posedge clk); #1;

    // Async reset with two queued entries
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 8'hFF, 8'h07, 3'd0);
    @(posedge clk); #1;
    drive(1'b1, 8'h00, 8'h30, 3'd1);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    chk("ar_valid_before", 32'(out_valid), 32'd1);
    chk("ar_head_before", 32'(out_y), 32'h07);
    chk("ar_full_before", 32'(in_ready), 32'd0);
`ifdef LOGIC_OP_PARITY_EN
    chk("ar_par_07", 32'(out_par), 32'd1);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_async", 32'(out_valid), 32'd0);
    chk("ar_y_async", 32'(out_y), 32'h00);
    chk("ar_count_async", 32'(op_count), 32'd0);
    chk("ar_ready_async", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ar_empty_after", 32'(out_valid), 32'd0);

    // Saturation on the CNT_W=4 instance
    @(negedge clk);
    s_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 9)  chk("sat_count_10", 32'(s_op_count), 32'd10);
      if (i == 14) chk("sat_count_15", 32'(s_op_count), 32'd15);
    end
    s_in_valid = 1'b0;
    chk("sat_count_final", 32'(s_op_count), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
